// File: rtl/nand_gate.sv
// Purpose : WIDTH-lane bitwise 3-input NAND with a registered copy and a saturating output-transition counter.
// Latency : y is combinational (0 cycles); y_q follows y by 1 clk; toggle_cnt updates on the same edge as y_q.
// Backpressure: none; the block accepts a new operand set every cycle and never stalls.
//
// Ports:
//   a, b, c    - NAND operands, WIDTH bits each
//   y          - combinational ~(a & b & c), independent of clk and rst
//   clk, rst   - rising-edge clock; asynchronous active-high reset
//   y_q        - y registered on every rising edge; resets to all ones
//   toggle_cnt - number of edges on which y_q changed, saturating at all ones
//   cnt_sat    - high while toggle_cnt sits at its maximum value
module nand_gate #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] y,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] y_q,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic             cnt_sat
);

    logic [WIDTH-1:0] y_q_q;
    logic [WIDTH-1:0] y_q_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             y_changes;
    logic             cnt_at_max;

    // A known 0 on any operand forces a 1 in that lane; unknowns on the
    // remaining operands propagate naturally through the reduction.
    assign y = ~(a & b & c);

    // Only the value actually present at the edge matters, so any amount of
    // input activity within one period collapses to at most one count.
    assign y_changes  = |(y ^ y_q_q);
    assign cnt_at_max = (cnt_q == {CNT_W{1'b1}});

    always_comb begin
        y_q_d = y;
        cnt_d = cnt_q;
        if (y_changes && !cnt_at_max) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Reset value of y_q is the NAND of all-zero operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q_q <= {WIDTH{1'b1}};
            cnt_q <= '0;
        end else begin
            y_q_q <= y_q_d;
            cnt_q <= cnt_d;
        end
    end

    assign y_q        = y_q_q;
    assign toggle_cnt = cnt_q;
    // cnt_q is cleared by reset, so this reads 0 throughout reset.
    assign cnt_sat    = cnt_at_max;

endmodule

// File: tb/tb_nand_gate.sv
module tb_nand_gate;

    localparam int W  = 4;
    localparam int CW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: 4 lanes, 16-bit counter
    logic          rst;
    logic [W-1:0]  a, b, c, y, y_q;
    logic [CW-1:0] cnt;
    logic          sat;

    // Saturation instance: 1 lane, 2-bit counter
    logic          rst2;
    logic          a2, b2, c2, y2, y2_q;
    logic [1:0]    cnt2;
    logic          sat2;

    nand_gate #(.WIDTH(W), .CNT_W(CW)) dut (
        .a(a), .b(b), .c(c), .y(y),
        .clk(clk), .rst(rst),
        .y_q(y_q), .toggle_cnt(cnt), .cnt_sat(sat)
    );

    nand_gate #(.WIDTH(1), .CNT_W(2)) dut_sat (
        .a(a2), .b(b2), .c(c2), .y(y2),
        .clk(clk), .rst(rst2),
        .y_q(y2_q), .toggle_cnt(cnt2), .cnt_sat(sat2)
    );

    localparam int K_Y     = 0;
    localparam int K_YQ    = 1;
    localparam int K_CNT   = 2;
    localparam int K_SAT   = 3;
    localparam int K_Y2Q   = 4;
    localparam int K_CNT2  = 5;
    localparam int K_SAT2  = 6;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    event sample_ev;
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic logic [31:0] actual(int kind);
        case (kind)
            K_Y:    return 32'(y);
            K_YQ:   return 32'(y_q);
            K_CNT:  return 32'(cnt);
            K_SAT:  return 32'(sat);
            K_Y2Q:  return 32'(y2_q);
            K_CNT2: return 32'(cnt2);
            K_SAT2: return 32'(sat2);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: whenever the driver presents the DUT outputs, drain the queue.
    initial begin : monitor
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(sample_ev);
            while (sb.size() > 0) begin
                e   = sb.pop_front();
                act = actual(e.kind);
                n_chk++;
                if (act === e.exp) n_pass++;
                else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", e.name, act, e.exp, $time);
            end
        end
    end

    task automatic push_exp(string nm, int kind, logic [31:0] e);
        exp_t item;
        item.name = nm;
        item.kind = kind;
        item.exp  = e;
        sb.push_back(item);
    endtask

    task automatic sample();
        -> sample_ev;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(logic [W-1:0] ai, logic [W-1:0] bi, logic [W-1:0] ci);
        a = ai;
        b = bi;
        c = ci;
    endtask

    // Hand-written truth table, index {a,b,c}: only 111 gives 0.
    logic [7:0]  tt_exp = 8'b0111_1111;
    logic [1:0]  cnt2_exp [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    logic        sat2_exp [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation time limit reached, expected completion before 50000");
        $fatal(1, "timeout");
    end

    initial begin : driver
        rst = 1'b1; rst2 = 1'b1;
        drive('0, '0, '0);
        a2 = 1'b0; b2 = 1'b0; c2 = 1'b0;
        #3;
        push_exp("rst_y",    K_Y,    32'hF);
        push_exp("rst_yq",   K_YQ,   32'hF);
        push_exp("rst_cnt",  K_CNT,  32'h0);
        push_exp("rst_sat",  K_SAT,  32'h0);
        push_exp("rst_cnt2", K_CNT2, 32'h0);
        push_exp("rst_sat2", K_SAT2, 32'h0);
        sample();

        // Truth-table sweep, all lanes identical; rst held, which must not matter for y
        for (int i = 0; i < 8; i++) begin
            drive({W{i[2]}}, {W{i[1]}}, {W{i[0]}});
            #1;
            push_exp($sformatf("tt_y_%0d%0d%0d", i[2], i[1], i[0]), K_Y, tt_exp[i] ? 32'hF : 32'h0);
            sample();
        end

        // Registered path after reset release
        tick();
        rst = 1'b0;
        drive('1, '1, '1);
        #1;
        push_exp("reg_y_immediate", K_Y,   32'h0);
        push_exp("reg_yq_before",   K_YQ,  32'hF);
        push_exp("reg_cnt_before",  K_CNT, 32'h0);
        sample();
        tick();
        push_exp("reg_yq_after",  K_YQ,  32'h0);
        push_exp("reg_cnt_after", K_CNT, 32'h1);
        sample();

        // Async reset between edges, then 10 alternating toggles
        rst = 1'b1;
        #1;
        push_exp("arst_yq",  K_YQ,  32'hF);
        push_exp("arst_cnt", K_CNT, 32'h0);
        push_exp("arst_y",   K_Y,   32'h0);
        sample();
        drive('0, '0, '0);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k % 2 == 0) drive('1, '1, '1);
            else            drive('0, '0, '0);
            tick();
            push_exp($sformatf("alt_yq_%0d", k),  K_YQ,  (k % 2 == 0) ? 32'h0 : 32'hF);
            push_exp($sformatf("alt_cnt_%0d", k), K_CNT, 32'(k + 1));
            sample();
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            push_exp($sformatf("hold_cnt_%0d", k), K_CNT, 32'd10);
            sample();
        end

        // Several input changes inside one period: at most one toggle
        drive('1, '1, '1); #1;
        drive('0, '0, '0); #1;
        drive('1, '1, '1);
        tick();
        push_exp("glitch_yq",  K_YQ,  32'h0);
        push_exp("glitch_cnt", K_CNT, 32'd11);
        sample();
        drive('0, '0, '0); #1;
        drive('1, '1, '1);
        tick();
        push_exp("glitch2_yq",  K_YQ,  32'h0);
        push_exp("glitch2_cnt", K_CNT, 32'd11);
        sample();

        // Reach count 5 with y_q=0, then reset mid-period
        rst = 1'b1; #1; rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k % 2 == 0) drive('1, '1, '1);
            else            drive('0, '0, '0);
            tick();
        end
        push_exp("pre_rst_cnt", K_CNT, 32'd5);
        push_exp("pre_rst_yq",  K_YQ,  32'h0);
        sample();
        #2;
        rst = 1'b1;
        #1;
        push_exp("mid_rst_cnt", K_CNT, 32'h0);
        push_exp("mid_rst_yq",  K_YQ,  32'hF);
        push_exp("mid_rst_y",   K_Y,   32'h0);
        push_exp("mid_rst_sat", K_SAT, 32'h0);
        sample();
        drive('0, '0, '0);
        #1;
        push_exp("in_rst_y_tracks", K_Y, 32'hF);
        sample();
        tick();
        push_exp("in_rst_edge_yq",  K_YQ,  32'hF);
        push_exp("in_rst_edge_cnt", K_CNT, 32'h0);
        sample();

        // Independent lanes
        drive(4'b1111, 4'b1010, 4'b1100);
        #1;
        push_exp("lane_y", K_Y, 32'h7);
        sample();
        rst = 1'b0;
        tick();
        push_exp("lane_yq",  K_YQ,  32'h7);
        push_exp("lane_cnt", K_CNT, 32'h1);
        sample();

        // Saturation with a 2-bit counter
        rst2 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            a2 = (k % 2 == 0); b2 = a2; c2 = a2;
            tick();
            push_exp($sformatf("sat_y2q_%0d", k),  K_Y2Q,  (k % 2 == 0) ? 32'h0 : 32'h1);
            push_exp($sformatf("sat_cnt2_%0d", k), K_CNT2, 32'(cnt2_exp[k]));
            push_exp($sformatf("sat_flag_%0d", k), K_SAT2, 32'(sat2_exp[k]));
            sample();
        end
        rst2 = 1'b1;
        #1;
        push_exp("sat_rst_cnt2", K_CNT2, 32'h0);
        push_exp("sat_rst_flag", K_SAT2, 32'h0);
        push_exp("sat_rst_y2q",  K_Y2Q,  32'h1);
        sample();

        #1;
        n_chk++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/nand_gate.md
NAND_GATE -- requirements
Module: nand_gate

Interface
REQ-001 Parameter WIDTH, default 1: number of independent bitwise NAND lanes.
REQ-002 Parameter CNT_W, default 16: width of the output-transition counter.
REQ-003 Port clk, input, 1 bit: single clock; all sequential logic on rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 Port a, input, WIDTH bits: NAND operand A.
REQ-006 Port b, input, WIDTH bits: NAND operand B.
REQ-007 Port c, input, WIDTH bits: NAND operand C.
REQ-008 Port y, output, WIDTH bits: combinational 3-input NAND result.
REQ-009 Port y_q, output, WIDTH bits: registered copy of y.
REQ-010 Port toggle_cnt, output, CNT_W bits: count of clock edges on which y_q changed value.
REQ-011 Port cnt_sat, output, 1 bit: high when toggle_cnt is at its maximum value.
REQ-012 Positional order for instantiation SHALL be a, b, c, y, then clk, rst, y_q, toggle_cnt, cnt_sat, so a four-port positional hookup (a, b, c, y) drives the combinational path.

Function
REQ-013 y SHALL equal ~(a & b & c) bitwise per lane, purely combinational, with zero clock latency and no dependence on clk or rst.
REQ-014 y SHALL be 0 in a lane only when a, b and c are all 1 in that lane; any 0 input gives 1.
REQ-015 X or Z on any input of a lane SHALL give X on that lane of y, except that a known 0 on any input forces 1.
REQ-016 y_q SHALL load y on every rising clk edge while rst is low, giving 1-cycle latency.
REQ-017 toggle_cnt SHALL increment by 1 on a rising edge when the value about to be loaded into y_q differs from the current y_q in any lane.
REQ-018 toggle_cnt SHALL saturate at 2^CNT_W-1 and hold there, with no wrap-around.
REQ-019 cnt_sat SHALL be combinational: high exactly when toggle_cnt equals 2^CNT_W-1.
REQ-020 Input changes between clock edges SHALL affect y immediately and y_q only at the next edge.
REQ-021 Multiple input changes within one clock period SHALL count as at most one toggle, and only if y_q changes.

Reset
REQ-022 Asserting rst SHALL immediately, with no clock needed, set y_q to all ones (the NAND of all-zero inputs) and toggle_cnt to 0.
REQ-023 cnt_sat SHALL read 0 during reset.
REQ-024 rst SHALL NOT affect y.
REQ-025 On the first rising edge after rst deasserts, y_q SHALL load the current y; that edge counts as a toggle if y differs from all ones.
REQ-026 Reset asserted mid-operation SHALL discard the count and the registered value immediately.

Verification
REQ-027 Truth-table sweep, WIDTH=1: (a,b,c) = 000 -> y=1; 011 -> y=1; 111 -> y=0; 101 -> y=1; all 8 combinations checked with zero delay.
REQ-028 Registered path: hold rst, then release; apply 111 -> y=0 immediately; y_q=0 after one edge; toggle_cnt=1.
REQ-029 Toggle count: alternate the inputs between 111 and 000 on 10 consecutive edges -> toggle_cnt=10; hold inputs steady for 5 edges -> toggle_cnt stays 10.
REQ-030 Saturation, CNT_W=2: 6 toggles -> toggle_cnt=3 and cnt_sat=1, held with no wrap.
REQ-031 Async reset: assert rst between edges while toggle_cnt=5 and y_q=0 -> toggle_cnt=0 and y_q=1 immediately; y tracks the inputs throughout.
REQ-032 Multi-lane, WIDTH=4: a=4'b1111, b=4'b1010, c=4'b1100 -> y=4'b0111.
